shift_sequencer: RTL
====================

# shift_sequencer

Command-driven controller sitting directly upstream of the 4-bit universal shift register. Accepts one command at a time (hold, shift right N, shift left N, parallel load) over a valid/ready handshake. Drives the register's mode select `s` and data input `a` for the required number of cycles, feeding the register's output `p` back as `a` during multi-bit shifts. Signals completion with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 4: data width; must equal the shift register width.
- `CNT_W`, 3: width of the shift-count field (max count 2^CNT_W−1).

- `clk` input 1: rising-edge clock, shared with the shift register.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: sequencer can accept a command.
- `cmd_op` input 2: operation; encoding identical to the register's `s`: 00 hold, 01 shift right (toward bit 0, MSB zero-fill), 10 shift left (toward MSB, bit 0 zero-fill), 11 load.
- `cmd_data` input WIDTH: load value, used for op 11 only.
- `cmd_count` input CNT_W: number of shift steps, used for ops 01/10 only.
- `p_fb` input WIDTH: shift register output `p`, fed back.
- `a` output WIDTH: drives register input `a`.
- `s` output 2: drives register input `s`.
- `busy` output 1: high while a command is executing.
- `done` output 1: one-cycle completion pulse.

## Operation
- States: IDLE, EXEC.
- Registered state: `op_q`, `data_q`, `cnt_q`.
- IDLE:
  - `cmd_ready`=1, `s`=00, `a`=`p_fb`.
  - On `cmd_valid`&`cmd_ready`, capture op/data/count.
- Transition IDLE→EXEC on accept, with the initial count depending on op:
  - op 11 (load): cnt_q=1.
  - op 00 (hold): cnt_q=1.
  - ops 01/10: cnt_q=cmd_count.
  - op 01/10 with cmd_count=0: no EXEC; stay IDLE and pulse `done` next cycle (zero-length command, register untouched).
- EXEC:
  - `cmd_ready`=0, `busy`=1, `s`=`op_q`.
  - `a`=`data_q` for load; `a`=`p_fb` for shifts and hold.
  - Each edge decrements cnt_q.
  - Edge where cnt_q==1 → IDLE.
- `done` is registered: high for exactly one cycle after the final EXEC edge (or after a zero-length accept).
- Shift counts ≥ WIDTH are legal; the result is all zeros after the full count (no saturation shortcut unless configured).
- `cmd_valid` is ignored while `cmd_ready`=0. Upstream holds `cmd_*` stable until accepted.
- `cmd_op`/`cmd_data`/`cmd_count` are sampled only at the accept edge; later changes have no effect.

## Timing
- Reset values (while `rst_n` low and after release):
  - state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `s`=00.
  - `a`=`p_fb` (register holds).
  - `op_q`/`data_q`/`cnt_q`=0.
- Accept at edge E0 with count N: `s` is the shift code during cycles E0+1..E0+N. The register updates at edges E0+1..E0+N.
- `done`=1 in the cycle after edge E0+N; `cmd_ready`=1 in that same cycle. Back-to-back throughput is N+1 cycles per command.
- Load and hold: 1 EXEC cycle; `done` two cycles after accept edge.
- `a` and `s` are combinational from state and `p_fb`, with no registered delay, so the register sees `p` fed straight back each step.
- Asynchronous reset mid-EXEC:
  - Immediate return to IDLE with `s`=00.
  - Any partial shift already applied to the register stays.
  - No `done` pulse.

## Configuration
- `SHIFT_SEQ_EARLY_ZERO_EN` defined:
  - A shift command with cmd_count ≥ WIDTH executes as one EXEC cycle with `s`=11 and `a`=0.
  - `done` arrives 2 cycles after accept.
  - The final register value is identical to the full-length shift.
- Undefined: every shift command runs its full cmd_count cycles.

## Structure
- Package `shift_seq_pkg`:
  - op encodings OP_HOLD=2'b00, OP_SHR=2'b01, OP_SHL=2'b10, OP_LOAD=2'b11.
  - state enum {ST_IDLE, ST_EXEC}.
- No sub-module: the FSM, down-counter and output mux live in one module.
- Integration test instantiates `shift_sequencer` plus `universal_shift` with `p` wired to `p_fb`.

## Test plan
- Reset, then load 4'b1011 → `s`=11 for one cycle; `p`=1011 after it; `done` pulse 2 cycles after accept.
- After loading 1011, shift right count 2 → `s`=01 for 2 cycles; `p`=0101, then 0010; `done` in cycle 3.
- Load 0011, shift left count 1 → `p`=0110; `busy` high exactly 1 cycle.
- Shift left count 0 → `s` stays 00; `p` unchanged; `done` the cycle after accept; `busy` never high.
- Load 1111, shift right count 7:
  - Macro off: 7 cycles of `s`=01, `p`=0000.
  - Macro on: 1 cycle of `s`=11 with `a`=0000, `p`=0000.
- `cmd_valid` held high through a 3-step shift with changed `cmd_*` → second command accepted only when `cmd_ready` returns. Assert `rst_n` low in its second EXEC cycle → `s`=00 immediately, no `done`, `cmd_ready`=1.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared op codes, FSM states and helpers for the shift sequencer.
// The op encoding matches the universal shift register mode select.
package shift_seq_pkg;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_SHR  = 2'b01;
   localparam logic [1:0] OP_SHL  = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   typedef enum logic {
      ST_IDLE,
      ST_EXEC
   } state_t;

   function automatic logic is_shift(input logic [1:0] op);
      return (op == OP_SHR) || (op == OP_SHL);
   endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Command channel of the shift sequencer: valid/ready plus payload.
// master = upstream command source, slave = sequencer.
interface shift_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [CNT_W-1:0] cmd_count;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_data,
      output cmd_count,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_data,
      input  cmd_count,
      output cmd_ready
   );

endinterface

// File: rtl/shift_sequencer.sv
// Command sequencer driving a 4-bit universal shift register (s/a).
// Optional SHIFT_SEQ_EARLY_ZERO_EN: long shifts collapse to a zero load.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   shift_sequencer_if.slave cmd,
   input  logic [WIDTH-1:0] p_fb,
   output logic [WIDTH-1:0] a,
   output logic [1:0]       s,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] data_q;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;

   logic             accept;
   logic             shift_cmd;
   logic             zero_len;
   logic             long_shift;

   assign accept    = cmd.cmd_valid && (state == ST_IDLE);
   assign shift_cmd = is_shift(cmd.cmd_op);
   assign zero_len  = shift_cmd && (cmd.cmd_count == '0);

`ifdef SHIFT_SEQ_EARLY_ZERO_EN
   assign long_shift = shift_cmd && (int'(cmd.cmd_count) >= WIDTH);
`else
   assign long_shift = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         op_q   <= OP_HOLD;
         data_q <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q   <= cmd.cmd_op;
                  data_q <= cmd.cmd_data;
                  cnt_q  <= shift_cmd ? cmd.cmd_count
                                      : CNT_W'(1);
                  if (long_shift) begin
                     // every bit falls off: a zero load is equivalent
                     op_q   <= OP_LOAD;
                     data_q <= '0;
                     cnt_q  <= CNT_W'(1);
                     state  <= ST_EXEC;
                  end else if (zero_len) begin
                     done_q <= 1'b1;
                  end else begin
                     state  <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state  <= ST_IDLE;
                  done_q <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // a/s stay combinational so p is fed straight back every step
   always_comb begin
      s = OP_HOLD;
      a = p_fb;
      if (state == ST_EXEC) begin
         s = op_q;
         if (op_q == OP_LOAD) begin
            a = data_q;
         end
      end
   end

   assign busy          = (state == ST_EXEC);
   assign cmd.cmd_ready = (state == ST_IDLE);
   assign done          = done_q;

endmodule
